// File: rtl/weight_buffer_pkg.sv
// Purpose: shared widths, types and helpers for the weight buffer slice.
// Contents: element/tile/word geometry, the load FSM state type and an
//           address increment helper that wraps modulo DEPTH.
package weight_buffer_pkg;

  localparam int ELEM_W         = 12;
  localparam int TILE_DIM       = 6;
  localparam int TILE_ELEMS     = TILE_DIM * TILE_DIM;
  localparam int BEAT_ELEMS     = 4;
  localparam int BEAT_W         = BEAT_ELEMS * ELEM_W;
  localparam int BEATS_PER_TILE = TILE_ELEMS / BEAT_ELEMS;
  localparam int TILE_BITS      = TILE_ELEMS * ELEM_W;
  localparam int DATA_W         = 512;
  localparam int DEPTH          = 256;
  localparam int ADDR_W         = 8;
  localparam int BEAT_CNT_W     = 4;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;

  // Next write address; ADDR_W-bit arithmetic wraps naturally at DEPTH.
  function automatic addr_t addr_inc(input addr_t a);
    return a + addr_t'(1);
  endfunction

endpackage

// File: rtl/weight_buffer_if.sv
// Purpose: bundles the loader stream and both read-request ports of the
//          weight buffer.
// Modports: slave  - the weight buffer (accepts beats, answers reads)
//           master - loader / weight controller side
interface weight_buffer_if;
  import weight_buffer_pkg::*;

  logic  load_start_i;
  addr_t load_base_addr_i;
  addr_t load_count_i;
  logic  load_valid_i;
  logic [BEAT_W-1:0] load_data_i;
  logic  load_ready_o;
  logic  load_busy_o;
  logic  load_done_o;

  logic  weight_package_1_valid_i;
  addr_t weight_addr_i_1;
  logic  weight_package_2_valid_i;
  addr_t weight_addr_i_2;
  word_t weight_data_o_1;
  addr_t weight_addr_o_1;
  logic  weight_valid_o_1;
  word_t weight_data_o_2;
  addr_t weight_addr_o_2;
  logic  weight_valid_o_2;

  modport slave (
    input  load_start_i, load_base_addr_i, load_count_i, load_valid_i, load_data_i,
    output load_ready_o, load_busy_o, load_done_o,
    input  weight_package_1_valid_i, weight_addr_i_1,
    input  weight_package_2_valid_i, weight_addr_i_2,
    output weight_data_o_1, weight_addr_o_1, weight_valid_o_1,
    output weight_data_o_2, weight_addr_o_2, weight_valid_o_2
  );

  modport master (
    output load_start_i, load_base_addr_i, load_count_i, load_valid_i, load_data_i,
    input  load_ready_o, load_busy_o, load_done_o,
    output weight_package_1_valid_i, weight_addr_i_1,
    output weight_package_2_valid_i, weight_addr_i_2,
    input  weight_data_o_1, weight_addr_o_1, weight_valid_o_1,
    input  weight_data_o_2, weight_addr_o_2, weight_valid_o_2
  );

endinterface

// File: rtl/weight_buffer_tile_packer.sv
// Purpose: collects 4-element load beats into one 36-element tile word.
// Ports: clk, reset (async active-low), clear (sync, restarts packing),
//        beat_valid/beat_data (accepted beat), word_valid/word (full tile,
//        presented combinationally in the cycle the 9th beat is accepted).
module weight_tile_packer
  import weight_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              beat_valid,
  input  logic [BEAT_W-1:0] beat_data,
  output logic              word_valid,
  output word_t             word
);

  // Only the first 8 beats need storing; the 9th goes straight into the word.
  localparam int PACK_W = TILE_BITS - BEAT_W;

  logic [BEAT_CNT_W-1:0] beat_cnt_r;
  logic [PACK_W-1:0]     pack_r;
  logic                  last_beat_s;

  // Detect the closing beat and assemble the word with zeroed upper bits.
  always_comb begin
    last_beat_s = beat_valid && (beat_cnt_r == BEAT_CNT_W'(BEATS_PER_TILE - 1));
    word_valid  = last_beat_s;
    word        = {{(DATA_W - TILE_BITS){1'b0}}, beat_data, pack_r};
  end

  // Beat counter and pack register; beat b lands in element slots 4b..4b+3.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt_r <= '0;
      pack_r     <= '0;
    end else if (clear) begin
      beat_cnt_r <= '0;
      pack_r     <= '0;
    end else if (beat_valid) begin
      if (last_beat_s) begin
        beat_cnt_r <= '0;
      end else begin
        beat_cnt_r <= beat_cnt_r + BEAT_CNT_W'(1);
        for (int b = 0; b < BEATS_PER_TILE - 1; b++) begin
          if (beat_cnt_r == BEAT_CNT_W'(b)) begin
            pack_r[b*BEAT_W +: BEAT_W] <= beat_data;
          end
        end
      end
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

endmodule

// File: rtl/weight_buffer.sv
// Purpose: on-chip weight store. Packs the loader stream into 6x6 tiles,
//          writes them to a 256 x 512-bit array and serves two independent
//          read ports with a fixed 1-cycle latency (address and valid echoed).
// Ports: clk, reset (async active-low), bus (weight_buffer_if.slave) carrying
//        the load stream, load status and both read request/response ports.
module weight_buffer
  import weight_buffer_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  weight_buffer_if.slave bus
);

  load_state_t state_r;
  load_state_t next_state_s;
  addr_t       wr_addr_r;
  addr_t       tile_cnt_r;
  addr_t       count_r;
  logic        start_s;
  logic        beat_valid_s;
  logic        last_tile_s;
  logic        word_valid_s;
  word_t       word_s;

  word_t mem_r [DEPTH];

  weight_tile_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_s),
    .beat_valid (beat_valid_s),
    .beat_data  (bus.load_data_i),
    .word_valid (word_valid_s),
    .word       (word_s)
  );

  // Handshake qualification, next-state logic and status outputs.
  always_comb begin
    start_s      = (state_r == IDLE) && bus.load_start_i;
    beat_valid_s = (state_r == LOAD) && bus.load_valid_i;
    // count_r >= 1 whenever LOAD is entered, so count_r - 1 is the last tile index.
    last_tile_s  = word_valid_s && (tile_cnt_r == (count_r - addr_t'(1)));
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          next_state_s = (bus.load_count_i == addr_t'(0)) ? DONE : LOAD;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD: begin
        if (last_tile_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = LOAD;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
    bus.load_ready_o = (state_r == LOAD);
    bus.load_busy_o  = (state_r != IDLE);
    bus.load_done_o  = (state_r == DONE);
  end

  // Load FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Write address, tile counter and latched tile count for the current load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_addr_r  <= '0;
      tile_cnt_r <= '0;
      count_r    <= '0;
    end else if (start_s) begin
      wr_addr_r  <= bus.load_base_addr_i;
      tile_cnt_r <= '0;
      count_r    <= bus.load_count_i;
    end else if (word_valid_s) begin
      wr_addr_r  <= addr_inc(wr_addr_r);
      tile_cnt_r <= tile_cnt_r + addr_t'(1);
    end else begin
      wr_addr_r  <= wr_addr_r;
    end
  end

  // Weight array write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (word_valid_s) begin
      mem_r[wr_addr_r] <= word_s;
    end
  end

  // Two registered read ports. Reading mem_r with nonblocking writes gives
  // read-first behaviour on a same-cycle collision. Data/addr hold when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.weight_valid_o_1 <= 1'b0;
      bus.weight_data_o_1  <= '0;
      bus.weight_addr_o_1  <= '0;
      bus.weight_valid_o_2 <= 1'b0;
      bus.weight_data_o_2  <= '0;
      bus.weight_addr_o_2  <= '0;
    end else begin
      bus.weight_valid_o_1 <= bus.weight_package_1_valid_i;
      bus.weight_valid_o_2 <= bus.weight_package_2_valid_i;
      if (bus.weight_package_1_valid_i) begin
        bus.weight_data_o_1 <= mem_r[bus.weight_addr_i_1];
        bus.weight_addr_o_1 <= bus.weight_addr_i_1;
      end else begin
        bus.weight_addr_o_1 <= bus.weight_addr_o_1;
      end
      if (bus.weight_package_2_valid_i) begin
        bus.weight_data_o_2 <= mem_r[bus.weight_addr_i_2];
        bus.weight_addr_o_2 <= bus.weight_addr_i_2;
      end else begin
        bus.weight_addr_o_2 <= bus.weight_addr_o_2;
      end
    end
  end

endmodule

// File: tb/tb_weight_buffer.sv
// Directed bench for weight_buffer: table-driven read vectors plus
// hand-written load, wrap, collision, reset and ignored-start sequences.
module tb_weight_buffer;
  import weight_buffer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  weight_buffer_if bus ();

  weight_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic  v1;  addr_t a1;
    logic  v2;  addr_t a2;
    logic  ev1; word_t ed1; addr_t ea1;
    logic  ev2; word_t ed2; addr_t ea2;
  } rd_vec_t;

  rd_vec_t vecs[$];
  word_t   t0, t1, tw0, tw1, tc, ts;

  task automatic check_word(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  function automatic word_t tile_word(input int off);
    word_t w;
    w = '0;
    for (int k = 0; k < TILE_ELEMS; k++) w[k*ELEM_W +: ELEM_W] = ELEM_W'(k + off);
    return w;
  endfunction

  function automatic logic [BEAT_W-1:0] build_beat(input int off, input int b);
    logic [BEAT_W-1:0] d;
    for (int j = 0; j < BEAT_ELEMS; j++) d[j*ELEM_W +: ELEM_W] = ELEM_W'(4*b + j + off);
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int off, input int b);
    bus.load_data_i  = build_beat(off, b);
    bus.load_valid_i = 1'b1;
    tick();
    bus.load_valid_i = 1'b0;
  endtask

  task automatic rd(input logic v1, input addr_t a1, input logic v2, input addr_t a2);
    bus.weight_package_1_valid_i = v1;
    bus.weight_addr_i_1          = a1;
    bus.weight_package_2_valid_i = v2;
    bus.weight_addr_i_2          = a2;
    tick();
    bus.weight_package_1_valid_i = 1'b0;
    bus.weight_package_2_valid_i = 1'b0;
  endtask

  task automatic start_load(input addr_t base, input addr_t cnt);
    bus.load_base_addr_i = base;
    bus.load_count_i     = cnt;
    bus.load_start_i     = 1'b1;
    tick();
    bus.load_start_i     = 1'b0;
  endtask

  // Full load of cnt tiles; optional idle cycle after every beat.
  task automatic load_run(input addr_t base, input addr_t cnt, input int off0,
                          input int off1, input bit gap, input string tag);
    int early;
    early = 0;
    start_load(base, cnt);
    check_bit({tag, "_ready"}, bus.load_ready_o, 1'b1);
    for (int t = 0; t < int'(cnt); t++) begin
      for (int b = 0; b < BEATS_PER_TILE; b++) begin
        send_beat((t == 0) ? off0 : off1, b);
        if (!(t == int'(cnt) - 1 && b == BEATS_PER_TILE - 1)) begin
          if (bus.load_done_o) early++;
          if (gap) begin
            tick();
            if (bus.load_done_o) early++;
          end
        end
      end
    end
    check_bit({tag, "_no_early_done"}, (early == 0), 1'b1);
    check_bit({tag, "_done"}, bus.load_done_o, 1'b1);
    tick();
    check_bit({tag, "_done_fall"}, bus.load_done_o, 1'b0);
    check_bit({tag, "_busy_fall"}, bus.load_busy_o, 1'b0);
  endtask

  task automatic apply_table(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      rd(vecs[i].v1, vecs[i].a1, vecs[i].v2, vecs[i].a2);
      check_bit ($sformatf("%s_v%0d_valid1", tag, i), bus.weight_valid_o_1, vecs[i].ev1);
      check_word($sformatf("%s_v%0d_data1", tag, i), bus.weight_data_o_1, vecs[i].ed1);
      check_word($sformatf("%s_v%0d_addr1", tag, i), word_t'(bus.weight_addr_o_1), word_t'(vecs[i].ea1));
      check_bit ($sformatf("%s_v%0d_valid2", tag, i), bus.weight_valid_o_2, vecs[i].ev2);
      check_word($sformatf("%s_v%0d_data2", tag, i), bus.weight_data_o_2, vecs[i].ed2);
      check_word($sformatf("%s_v%0d_addr2", tag, i), word_t'(bus.weight_addr_o_2), word_t'(vecs[i].ea2));
    end
  endtask

  initial begin
    int dropped_done;
    t0  = tile_word(1);
    t1  = tile_word(101);
    tw0 = tile_word(1001);
    tw1 = tile_word(2001);
    tc  = tile_word(51);
    ts  = tile_word(3001);

    vecs.push_back('{1'b1, 8'h10, 1'b1, 8'h11, 1'b1, t0, 8'h10, 1'b1, t1, 8'h11});
    vecs.push_back('{1'b1, 8'h11, 1'b1, 8'h11, 1'b1, t1, 8'h11, 1'b1, t1, 8'h11});
    vecs.push_back('{1'b0, 8'h10, 1'b1, 8'h10, 1'b0, t1, 8'h11, 1'b1, t0, 8'h10});
    vecs.push_back('{1'b0, 8'h33, 1'b0, 8'h44, 1'b0, t1, 8'h11, 1'b0, t0, 8'h10});
    vecs.push_back('{1'b1, 8'h10, 1'b0, 8'h55, 1'b1, t0, 8'h10, 1'b0, t0, 8'h10});

    bus.load_start_i = 1'b0; bus.load_base_addr_i = '0; bus.load_count_i = '0;
    bus.load_valid_i = 1'b0; bus.load_data_i = '0;
    bus.weight_package_1_valid_i = 1'b0; bus.weight_addr_i_1 = '0;
    bus.weight_package_2_valid_i = 1'b0; bus.weight_addr_i_2 = '0;

    reset = 1'b0;
    tick(); tick();
    check_bit ("rst_ready",  bus.load_ready_o, 1'b0);
    check_bit ("rst_busy",   bus.load_busy_o,  1'b0);
    check_bit ("rst_done",   bus.load_done_o,  1'b0);
    check_bit ("rst_valid1", bus.weight_valid_o_1, 1'b0);
    check_word("rst_addr2",  word_t'(bus.weight_addr_o_2), '0);
    reset = 1'b1;
    tick();
    check_bit("idle_ready", bus.load_ready_o, 1'b0);

    // Reset asserted part-way through a tile while a read is in flight.
    start_load(8'h40, 8'd1);
    for (int b = 0; b < 4; b++) send_beat(7, b);
    bus.load_valid_i = 1'b1;
    bus.weight_package_1_valid_i = 1'b1; bus.weight_addr_i_1 = 8'h40;
    tick();
    check_bit("pre_rst_busy", bus.load_busy_o, 1'b1);
    reset = 1'b0;
    #1;
    check_bit ("midrst_ready",  bus.load_ready_o, 1'b0);
    check_bit ("midrst_busy",   bus.load_busy_o,  1'b0);
    check_bit ("midrst_valid1", bus.weight_valid_o_1, 1'b0);
    check_word("midrst_addr1",  word_t'(bus.weight_addr_o_1), '0);
    check_word("midrst_data1",  bus.weight_data_o_1, '0);
    tick();
    check_bit("midrst_held_ready", bus.load_ready_o, 1'b0);
    reset = 1'b1;
    bus.weight_package_1_valid_i = 1'b0;
    dropped_done = 0;
    for (int b = 0; b < BEATS_PER_TILE; b++) begin
      send_beat(9, b);
      if (bus.load_done_o || bus.load_busy_o || bus.load_ready_o) dropped_done++;
    end
    check_bit("post_rst_idle", (dropped_done == 0), 1'b1);

    // Basic two-tile load, then table reads.
    load_run(8'h10, 8'd2, 1, 101, 1'b0, "load2");
    apply_table("tab_a");

    // Same load with valid toggling: same contents.
    load_run(8'h10, 8'd2, 1, 101, 1'b1, "gap");
    apply_table("tab_b");

    // Address wrap.
    load_run(8'hFF, 8'd2, 1001, 2001, 1'b0, "wrap");
    rd(1'b1, 8'hFF, 1'b1, 8'h00);
    check_word("wrap_ff", bus.weight_data_o_1, tw0);
    check_word("wrap_00", bus.weight_data_o_2, tw1);

    // Read of 0x10 in the same cycle its new word is written: old data.
    start_load(8'h10, 8'd1);
    for (int b = 0; b < BEATS_PER_TILE - 1; b++) send_beat(51, b);
    bus.weight_package_1_valid_i = 1'b1; bus.weight_addr_i_1 = 8'h10;
    bus.weight_package_2_valid_i = 1'b1; bus.weight_addr_i_2 = 8'h10;
    send_beat(51, BEATS_PER_TILE - 1);
    bus.weight_package_1_valid_i = 1'b0; bus.weight_package_2_valid_i = 1'b0;
    check_bit ("coll_done", bus.load_done_o, 1'b1);
    check_word("coll_old1", bus.weight_data_o_1, t0);
    check_word("coll_old2", bus.weight_data_o_2, t0);
    rd(1'b1, 8'h10, 1'b0, 8'h00);
    check_word("coll_new", bus.weight_data_o_1, tc);

    // Zero-count load: done one cycle after start, nothing written.
    start_load(8'h11, 8'd0);
    check_bit("zero_done",  bus.load_done_o,  1'b1);
    check_bit("zero_ready", bus.load_ready_o, 1'b0);
    tick();
    check_bit("zero_done_fall", bus.load_done_o, 1'b0);
    rd(1'b1, 8'h11, 1'b0, 8'h00);
    check_word("zero_nowrite", bus.weight_data_o_1, t1);

    // Start pulse during LOAD is ignored.
    start_load(8'h20, 8'd1);
    for (int b = 0; b < 3; b++) send_beat(3001, b);
    start_load(8'h30, 8'd3);
    check_bit("ign_ready", bus.load_ready_o, 1'b1);
    for (int b = 3; b < BEATS_PER_TILE; b++) send_beat(3001, b);
    check_bit("ign_done", bus.load_done_o, 1'b1);
    tick();
    rd(1'b1, 8'h20, 1'b0, 8'h00);
    check_word("ign_base", bus.weight_data_o_1, ts);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
